eth_sma_fifo_buf: RTL

- Command/response buffer between the register bank (host side) and the SMA master protocol engine (PE side) of the ethernet MDIO controller.
- TX path: host pushes 23-bit MDIO command entries; the PE reads them through tx_fifo_re/data/num.
- RX path: the PE writes 16-bit read-data words through rx_fifo_we/data; the host pops them.
- Both paths are first-word-fall-through (FWFT) synchronous FIFOs with occupancy counts and logic clear.

---
 rtl/eth_sma_fifo_buf_pkg.sv | 30 +++
 rtl/eth_sma_fifo_buf_if.sv | 50 +++++
 rtl/eth_sma_fifo_buf_sync_fifo.sv | 94 +++++++++
 rtl/eth_sma_fifo_buf.sv | 70 +++++++
 4 files changed

// File: rtl/eth_sma_fifo_buf_pkg.sv
// Shared definitions for the SMA command/response buffer.
// Contents: SMA op codes, TX entry field positions, FIFO widths and depth,
// and a helper that packs a TX command entry from its fields.
package eth_sma_pkg;

   localparam int unsigned TX_WIDTH = 23;
   localparam int unsigned RX_WIDTH = 16;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned AW       = $clog2(DEPTH);

   // TX entry layout: {op[1:0], regad[4:0], data[15:0]}
   localparam int unsigned OP_MSB    = 22;
   localparam int unsigned OP_LSB    = 21;
   localparam int unsigned REGAD_MSB = 20;
   localparam int unsigned REGAD_LSB = 16;
   localparam int unsigned DATA_MSB  = 15;
   localparam int unsigned DATA_LSB  = 0;

   typedef enum logic [1:0] {
      SMA_OP_WR = 2'b01,
      SMA_OP_RD = 2'b10
   } sma_op_e;

   function automatic logic [TX_WIDTH-1:0] sma_cmd(input sma_op_e op,
                                                   input logic [4:0] regad,
                                                   input logic [15:0] data);
      return {op, regad, data};
   endfunction

endpackage

// File: rtl/eth_sma_fifo_buf_if.sv
// Bus bundle between the register bank (host), the SMA protocol engine (PE)
// and the command/response buffer.
// Modports:
//   slave  - the buffer: takes pushes/pops, drives heads, counts and status.
//   master - the users: drive pushes/pops and write data, observe the rest.
// Optional ETH_SMA_FIFO_ERR_EN adds the sticky error flags
// host_tx_ovf, host_rx_udf, pe_rx_ovf and pe_tx_udf.
interface eth_sma_fifo_buf_if;
   import eth_sma_pkg::*;

   logic                host_tx_push;
   logic [TX_WIDTH-1:0] host_tx_wdata;
   logic                host_tx_full;
   logic [AW:0]         host_tx_num;
   logic                host_rx_pop;
   logic [RX_WIDTH-1:0] host_rx_rdata;
   logic                host_rx_empty;
   logic [AW:0]         host_rx_num;
   logic                tx_fifo_re;
   logic [TX_WIDTH-1:0] tx_fifo_data;
   logic [AW:0]         tx_fifo_num;
   logic                rx_fifo_we;
   logic [RX_WIDTH-1:0] rx_fifo_data;
   logic [AW:0]         rx_fifo_num;
`ifdef ETH_SMA_FIFO_ERR_EN
   logic                host_tx_ovf;
   logic                host_rx_udf;
   logic                pe_rx_ovf;
   logic                pe_tx_udf;
`endif

   modport slave (
      input  host_tx_push, host_tx_wdata, host_rx_pop, tx_fifo_re, rx_fifo_we, rx_fifo_data,
      output host_tx_full, host_tx_num, host_rx_rdata, host_rx_empty, host_rx_num,
             tx_fifo_data, tx_fifo_num, rx_fifo_num
`ifdef ETH_SMA_FIFO_ERR_EN
             , host_tx_ovf, host_rx_udf, pe_rx_ovf, pe_tx_udf
`endif
   );

   modport master (
      output host_tx_push, host_tx_wdata, host_rx_pop, tx_fifo_re, rx_fifo_we, rx_fifo_data,
      input  host_tx_full, host_tx_num, host_rx_rdata, host_rx_empty, host_rx_num,
             tx_fifo_data, tx_fifo_num, rx_fifo_num
`ifdef ETH_SMA_FIFO_ERR_EN
             , host_tx_ovf, host_rx_udf, pe_rx_ovf, pe_tx_udf
`endif
   );

endinterface

// File: rtl/eth_sma_fifo_buf_sync_fifo.sv
// eth_sma_sync_fifo: generic first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rstn (sync, active low), clr (sync flush)
//   we/wdata  - push; dropped while full
//   re/rdata  - pop; ignored while empty; rdata is the head, combinational
//   num       - occupancy, full, empty
//   ovf/udf   - sticky dropped-push / ignored-pop flags (ETH_SMA_FIFO_ERR_EN only)
// DEPTH must be a power of 2 so the pointers wrap by plain overflow.
module eth_sma_sync_fifo #(
   parameter int unsigned WIDTH = 23,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      num,
   output logic             full,
   output logic             empty
`ifdef ETH_SMA_FIFO_ERR_EN
   ,
   output logic             ovf,
   output logic             udf
`endif
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   // Acceptance is judged on the pre-edge count, so a pop never frees room
   // for a same-cycle push when full, nor a push feeds a pop when empty.
   assign push_ok = we && (cnt_q != FULL_CNT);
   assign pop_ok  = re && (cnt_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push_ok) mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Head is stale storage when empty; consumers qualify with num/empty.
   assign rdata = mem_q[rd_ptr_q];
   assign num   = cnt_q;
   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);

`ifdef ETH_SMA_FIFO_ERR_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (we && !push_ok);
         udf_q <= udf_q | (re && !pop_ok);
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`endif

endmodule

// File: rtl/eth_sma_fifo_buf.sv
// eth_sma_fifo_buf: command/response buffer between the MDIO register bank
// (host) and the SMA master protocol engine (PE).
// Ports:
//   pe_clk    - sole clock
//   pe_rstn   - synchronous active-low reset
//   logic_clr - synchronous flush of both FIFOs, wins over push/pop
//   bus       - eth_sma_fifo_buf_if.slave: TX path host->PE (23-bit commands),
//               RX path PE->host (16-bit read data), counts and status.
// Optional ETH_SMA_FIFO_ERR_EN adds sticky host_tx_ovf, host_rx_udf,
// pe_rx_ovf and pe_tx_udf on the bus.
module eth_sma_fifo_buf
   import eth_sma_pkg::*;
(
   input logic               pe_clk,
   input logic               pe_rstn,
   input logic               logic_clr,
   eth_sma_fifo_buf_if.slave bus
);

   logic [AW:0] tx_num, rx_num;
   logic        tx_empty_unused, rx_full_unused;

   eth_sma_sync_fifo #(
      .WIDTH(TX_WIDTH),
      .DEPTH(DEPTH)
   ) u_tx_fifo (
      .clk   (pe_clk),
      .rstn  (pe_rstn),
      .clr   (logic_clr),
      .we    (bus.host_tx_push),
      .wdata (bus.host_tx_wdata),
      .re    (bus.tx_fifo_re),
      .rdata (bus.tx_fifo_data),
      .num   (tx_num),
      .full  (bus.host_tx_full),
      .empty (tx_empty_unused)
`ifdef ETH_SMA_FIFO_ERR_EN
      ,
      .ovf   (bus.host_tx_ovf),
      .udf   (bus.pe_tx_udf)
`endif
   );

   eth_sma_sync_fifo #(
      .WIDTH(RX_WIDTH),
      .DEPTH(DEPTH)
   ) u_rx_fifo (
      .clk   (pe_clk),
      .rstn  (pe_rstn),
      .clr   (logic_clr),
      .we    (bus.rx_fifo_we),
      .wdata (bus.rx_fifo_data),
      .re    (bus.host_rx_pop),
      .rdata (bus.host_rx_rdata),
      .num   (rx_num),
      .full  (rx_full_unused),
      .empty (bus.host_rx_empty)
`ifdef ETH_SMA_FIFO_ERR_EN
      ,
      .ovf   (bus.pe_rx_ovf),
      .udf   (bus.host_rx_udf)
`endif
   );

   assign bus.host_tx_num = tx_num;
   assign bus.tx_fifo_num = tx_num;
   assign bus.host_rx_num = rx_num;
   assign bus.rx_fifo_num = rx_num;

endmodule
